// File: rtl/reg_unit_pkg.sv
// reg_unit_pkg: shared defaults, types and index helper for the register unit
package reg_unit_pkg;
    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int DEF_AW = $clog2(DEF_NREG);
    typedef logic [DEF_AW-1:0] reg_addr_t;
    typedef logic [DEF_XLEN-1:0] xword_t;
    function automatic logic zero_idx_f(input int unsigned idx);
        return idx == 0;
    endfunction
endpackage

// File: rtl/wr_en_dec.sv
// wr_en_dec: AW-to-NREG one-hot decoder with enable, index 0 never asserted
module wr_en_dec
    import reg_unit_pkg::*;
#(
    parameter int AW = 5,
    parameter int NREG = 32
) (
    input  logic            en,
    input  logic [AW-1:0]   idx,
    output logic [NREG-1:0] oh
);
    for (genvar i = 0; i < NREG; i++) begin : g_oh
        assign oh[i] = en && idx == AW'(i) && !zero_idx_f(i);
    end
endmodule

// File: rtl/reg_unit_param.sv
// reg_unit_param: parametrised register file with bypass and pending-write scoreboard
module reg_unit_param
    import reg_unit_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRD = 2,
    parameter int BYPASS = 1,
    localparam int AW = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                RuWr,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    output logic [NREG-1:0]     busy,
    output logic [NRD-1:0]      hazard
);
    logic [NREG-1:0] wr_en;
    logic [NREG-1:0] iss_set;
    logic [XLEN-1:0] regs [NREG];

    wr_en_dec #(.AW(AW), .NREG(NREG)) u_wr_dec (.en(RuWr), .idx(rd), .oh(wr_en));
    wr_en_dec #(.AW(AW), .NREG(NREG)) u_iss_dec (.en(iss_valid), .idx(iss_rd), .oh(iss_set));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) if (wr_en[i]) regs[i] <= wr_data;
        end
    end

    // set is applied after clear so a new producer wins over a completing one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else busy <= (busy & ~wr_en) | iss_set;
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0] a;
        logic hit;
        assign a = rs_addr[p*AW +: AW];
        assign hit = BYPASS != 0 && RuWr && rd == a;
        assign rs_data[p*XLEN +: XLEN] = zero_idx_f(32'(a)) ? '0 : hit ? wr_data : regs[a];
        assign hazard[p] = busy[a] && !hit;
    end
endmodule

// File: tb/tb_reg_unit_param.sv
// tb_reg_unit_param: directed checks on BYPASS=1 and BYPASS=0 builds side by side
module tb_reg_unit_param;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        RuWr = 0;
    logic [4:0]  rd = 0;
    logic [31:0] wr_data = 0;
    logic [9:0]  rs_addr = 0;
    logic        iss_valid = 0;
    logic [4:0]  iss_rd = 0;
    logic [63:0] rs_data_b, rs_data_n;
    logic [31:0] busy_b, busy_n;
    logic [1:0]  hazard_b, hazard_n;
    int tests = 0;
    int fails = 0;

    reg_unit_param #(.BYPASS(1)) dut_b (.clk(clk), .rst_n(rst_n), .RuWr(RuWr), .rd(rd),
        .wr_data(wr_data), .rs_addr(rs_addr), .rs_data(rs_data_b), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .busy(busy_b), .hazard(hazard_b));
    reg_unit_param #(.BYPASS(0)) dut_n (.clk(clk), .rst_n(rst_n), .RuWr(RuWr), .rd(rd),
        .wr_data(wr_data), .rs_addr(rs_addr), .rs_data(rs_data_n), .iss_valid(iss_valid),
        .iss_rd(iss_rd), .busy(busy_n), .hazard(hazard_n));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({busy_b, busy_n} !== 64'h0) begin
            fails++;
            $display("FAIL reset_busy got %h %h want 0", busy_b, busy_n);
        end
        step();
        step();
        rs_addr = {5'd3, 5'd1};
        #1;
        tests++;
        if ({rs_data_b, rs_data_n, hazard_b, hazard_n} !== 132'h0) begin
            fails++;
            $display("FAIL reset_read got %h %h hz %b %b want 0", rs_data_b, rs_data_n, hazard_b, hazard_n);
        end
        rst_n = 1;
    endtask

    task automatic test_write();
        RuWr = 1; rd = 5; wr_data = 32'hDEADBEEF;
        step();
        RuWr = 0;
        rs_addr = {5'd6, 5'd5};
        #1;
        tests++;
        if (rs_data_b !== {32'h0, 32'hDEADBEEF} || rs_data_n !== {32'h0, 32'hDEADBEEF}) begin
            fails++;
            $display("FAIL write_r5 got %h %h want 00000000deadbeef", rs_data_b, rs_data_n);
        end
        for (int i = 1; i < 5; i++) begin
            rs_addr = {5'(i), 5'(i + 26)};
            #1;
            tests++;
            if ({rs_data_b, rs_data_n} !== 128'h0) begin
                fails++;
                $display("FAIL write_others idx %0d got %h %h want 0", i, rs_data_b, rs_data_n);
            end
        end
    endtask

    task automatic test_zero();
        RuWr = 1; rd = 0; wr_data = 32'hFFFFFFFF;
        rs_addr = {5'd0, 5'd0};
        #1;
        tests++;
        if ({rs_data_b, rs_data_n} !== 128'h0) begin
            fails++;
            $display("FAIL zero_before got %h %h want 0", rs_data_b, rs_data_n);
        end
        step();
        RuWr = 0;
        #1;
        tests++;
        if ({rs_data_b, rs_data_n} !== 128'h0) begin
            fails++;
            $display("FAIL zero_after got %h %h want 0", rs_data_b, rs_data_n);
        end
    endtask

    task automatic test_bypass();
        RuWr = 1; rd = 7; wr_data = 32'h1;
        step();
        wr_data = 32'h2A;
        rs_addr = {5'd7, 5'd5};
        #1;
        tests++;
        if (rs_data_b[63:32] !== 32'h2A || rs_data_n[63:32] !== 32'h1) begin
            fails++;
            $display("FAIL bypass_same_cycle got %h %h want 0000002a 00000001", rs_data_b[63:32], rs_data_n[63:32]);
        end
        step();
        RuWr = 0;
        #1;
        tests++;
        if (rs_data_b[63:32] !== 32'h2A || rs_data_n[63:32] !== 32'h2A) begin
            fails++;
            $display("FAIL bypass_after got %h %h want 0000002a", rs_data_b[63:32], rs_data_n[63:32]);
        end
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_rd = 9;
        step();
        iss_valid = 0;
        rs_addr = {5'd5, 5'd9};
        #1;
        tests++;
        if (busy_b !== 32'h200 || busy_n !== 32'h200) begin
            fails++;
            $display("FAIL sb_set got %h %h want 00000200", busy_b, busy_n);
        end
        tests++;
        if (hazard_b !== 2'b01 || hazard_n !== 2'b01) begin
            fails++;
            $display("FAIL sb_hazard got %b %b want 01", hazard_b, hazard_n);
        end
        RuWr = 1; rd = 9; wr_data = 32'h99;
        #1;
        tests++;
        if (hazard_b !== 2'b00 || hazard_n !== 2'b01) begin
            fails++;
            $display("FAIL sb_wb_hazard got %b %b want 00 01", hazard_b, hazard_n);
        end
        step();
        RuWr = 0;
        #1;
        tests++;
        if ({busy_b, busy_n} !== 64'h0 || {hazard_b, hazard_n} !== 4'b0) begin
            fails++;
            $display("FAIL sb_clear got %h %h hz %b %b want 0", busy_b, busy_n, hazard_b, hazard_n);
        end
        iss_valid = 1; iss_rd = 0;
        step();
        iss_valid = 0;
        #1;
        tests++;
        if ({busy_b, busy_n} !== 64'h0) begin
            fails++;
            $display("FAIL sb_iss_zero got %h %h want 0", busy_b, busy_n);
        end
    endtask

    task automatic test_set_wins();
        iss_valid = 1; iss_rd = 3;
        step();
        RuWr = 1; rd = 3; wr_data = 32'h33;
        step();
        iss_valid = 0; RuWr = 0;
        rs_addr = {5'd3, 5'd3};
        #1;
        tests++;
        if (busy_b !== 32'h8 || busy_n !== 32'h8) begin
            fails++;
            $display("FAIL setwins_busy got %h %h want 00000008", busy_b, busy_n);
        end
        tests++;
        if (rs_data_b !== {2{32'h33}} || rs_data_n !== {2{32'h33}}) begin
            fails++;
            $display("FAIL setwins_data got %h %h want 33 on both ports", rs_data_b, rs_data_n);
        end
        RuWr = 1; rd = 3; wr_data = 32'h34;
        step();
        RuWr = 0;
    endtask

    task automatic test_reset_mid();
        for (int i = 8; i < 12; i++) begin
            iss_valid = 1; iss_rd = 5'(i);
            step();
        end
        iss_valid = 0;
        rs_addr = {5'd9, 5'd5};
        #1;
        tests++;
        if (busy_b !== 32'h0F00 || busy_n !== 32'h0F00 || hazard_b !== 2'b10 || rs_data_b[31:0] !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL mid_pre got %h %h hz %b data %h want 00000f00 10 deadbeef", busy_b, busy_n, hazard_b, rs_data_b[31:0]);
        end
        #1;
        rst_n = 0;
        RuWr = 1; rd = 12; wr_data = 32'h55;
        #1;
        tests++;
        if ({busy_b, busy_n} !== 64'h0 || {rs_data_b, rs_data_n} !== 128'h0 || {hazard_b, hazard_n} !== 4'b0) begin
            fails++;
            $display("FAIL mid_reset got busy %h %h data %h %h hz %b %b want 0", busy_b, busy_n, rs_data_b, rs_data_n, hazard_b, hazard_n);
        end
        step();
        RuWr = 0;
        rst_n = 1;
        rs_addr = {5'd7, 5'd12};
        #1;
        tests++;
        if ({rs_data_b, rs_data_n} !== 128'h0 || {busy_b, busy_n} !== 64'h0) begin
            fails++;
            $display("FAIL mid_lost_write got %h %h busy %h %h want 0", rs_data_b, rs_data_n, busy_b, busy_n);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero();
        test_bypass();
        test_scoreboard();
        test_set_wins();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
